// File: rtl/song_scheduler.sv
// song_scheduler: walks the song ROM for auto-play and learning modes and hands the tone path to live keys in free mode.
// Build option LEARN_TIMEOUT_EN: a learning-mode key wait expires after 16 duration units and the note is skipped.
module song_scheduler #(
    parameter int TICK_DIV = 12_500_000,
    parameter int SONG_AW  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         mode,
    input  logic [6:0]         keys,
    input  logic               start,
    output logic [SONG_AW-1:0] rom_addr,
    input  logic [7:0]         rom_data,
    output logic [3:0]         note_out,
    output logic [6:0]         led_hint,
    output logic               busy,
    output logic               done,
    output logic [7:0]         wrong_cnt
);
    localparam logic [2:0] MODE_FREE  = 3'b001;
    localparam logic [2:0] MODE_AUTO  = 3'b010;
    localparam logic [2:0] MODE_LEARN = 3'b100;
    localparam int         CNT_W      = $clog2(16 * TICK_DIV + 1);
    localparam logic [CNT_W-1:0] GAP_LEN = CNT_W'(TICK_DIV - 1);
`ifdef LEARN_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LEN = CNT_W'(16 * TICK_DIV - 1);
`endif

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP, WAIT_KEY, FINISH} state_t;

    state_t           state;
    logic [2:0]       song_mode;
    logic [3:0]       note_r;
    logic [3:0]       dur_r;
    logic [6:0]       keys_prev;
    logic [6:0]       rise;
    logic [CNT_W-1:0] cnt;

    assign rise = keys & ~keys_prev;

    function automatic logic [3:0] lowest_key(input logic [6:0] k);
        lowest_key = 4'd0;
        for (int i = 6; i >= 0; i--) begin
            if (k[i]) lowest_key = 4'(i + 1);
        end
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Counter is loaded with length-1 and the state exits when it reaches zero.
    function automatic logic [CNT_W-1:0] play_len(input logic [3:0] d);
        return CNT_W'(d) * CNT_W'(TICK_DIV) - CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            song_mode <= 3'b000;
            note_r    <= 4'd0;
            dur_r     <= 4'd0;
            keys_prev <= 7'd0;
            cnt       <= '0;
            rom_addr  <= '0;
            note_out  <= 4'd0;
            led_hint  <= 7'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrong_cnt <= 8'd0;
        end else begin
            keys_prev <= keys;
            done      <= 1'b0;
            if (state != IDLE && mode != song_mode) begin
                // Mode switch mid-song aborts silently, without a done pulse.
                state    <= IDLE;
                busy     <= 1'b0;
                note_out <= 4'd0;
                led_hint <= 7'd0;
            end else begin
                case (state)
                    IDLE: begin
                        note_out <= (mode == MODE_FREE) ? lowest_key(keys) : 4'd0;
                        if (start && (mode == MODE_AUTO || mode == MODE_LEARN)) begin
                            rom_addr  <= '0;
                            wrong_cnt <= 8'd0;
                            song_mode <= mode;
                            busy      <= 1'b1;
                            state     <= FETCH;
                        end
                    end
                    FETCH: state <= LOAD;
                    LOAD: begin
                        note_r <= rom_data[7:4];
                        dur_r  <= rom_data[3:0];
                        if (rom_data[3:0] == 4'd0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else if (song_mode == MODE_LEARN && rom_data[7:4] >= 4'd1
                                     && rom_data[7:4] <= 4'd7) begin
                            state    <= WAIT_KEY;
                            led_hint <= 7'(1) << (rom_data[7:4] - 4'd1);
`ifdef LEARN_TIMEOUT_EN
                            cnt      <= TIMEOUT_LEN;
`endif
                        end else begin
                            state    <= PLAY;
                            note_out <= rom_data[7] ? 4'd0 : rom_data[7:4];
                            cnt      <= play_len(rom_data[3:0]);
                        end
                    end
                    WAIT_KEY: begin
                        // led_hint doubles as the expected-key mask while waiting.
                        if ((rise & led_hint) != 7'd0) begin
                            state    <= PLAY;
                            note_out <= note_r;
                            led_hint <= 7'd0;
                            cnt      <= play_len(dur_r);
                        end else begin
                            if (rise != 7'd0) wrong_cnt <= sat_inc(wrong_cnt);
`ifdef LEARN_TIMEOUT_EN
                            if (cnt == '0) begin
                                wrong_cnt <= sat_inc(wrong_cnt);
                                state     <= GAP;
                                led_hint  <= 7'd0;
                                cnt       <= GAP_LEN;
                            end else begin
                                cnt <= cnt - CNT_W'(1);
                            end
`endif
                        end
                    end
                    PLAY: begin
                        if (cnt == '0) begin
                            state    <= GAP;
                            note_out <= 4'd0;
                            cnt      <= GAP_LEN;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    GAP: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_W'(1);
                        end else if (&rom_addr) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= FETCH;
                        end
                    end
                    FINISH: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_song_scheduler.sv
// tb_song_scheduler: randomized bench for song_scheduler; expected behaviour comes from a per-cycle timeline model.
`timescale 1ns/1ps
module tb_song_scheduler;
    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] mode = 3'b000;
    logic [6:0] keys = 7'd0;
    logic       start = 1'b0;

    logic [5:0] rom_addr;
    logic [7:0] rom_data;
    logic [3:0] note_out;
    logic [6:0] led_hint;
    logic       busy, done;
    logic [7:0] wrong_cnt;

    logic [1:0] rom_addr2;
    logic [7:0] rom_data2;
    logic [3:0] note_out2;
    logic [6:0] led_hint2;
    logic       busy2, done2;
    logic [7:0] wrong_cnt2;

    logic [7:0] rom1 [64];
    logic [7:0] rom2 [4];

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic [3:0] note;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t expq[$];
    int   exp_last_addr;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data  <= rom1[rom_addr];
    always @(posedge clk) rom_data2 <= rom2[rom_addr2];

    song_scheduler #(.TICK_DIV(T), .SONG_AW(6)) dut (
        .clk(clk), .rst(rst), .mode(mode), .keys(keys), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data), .note_out(note_out),
        .led_hint(led_hint), .busy(busy), .done(done), .wrong_cnt(wrong_cnt)
    );

    song_scheduler #(.TICK_DIV(T), .SONG_AW(2)) dut2 (
        .clk(clk), .rst(rst), .mode(mode), .keys(keys), .start(start),
        .rom_addr(rom_addr2), .rom_data(rom_data2), .note_out(note_out2),
        .led_hint(led_hint2), .busy(busy2), .done(done2), .wrong_cnt(wrong_cnt2)
    );

    // Cycle-by-cycle expectation for an auto-play song, starting with the cycle after start is taken.
    function automatic void build_timeline(input logic [7:0] r [64], input int depth);
        int         addr;
        int         dur;
        logic [3:0] nt;
        expq.delete();
        addr = 0;
        expq.push_back({4'd0, 1'b1, 1'b0});
        expq.push_back({4'd0, 1'b1, 1'b0});
        while (1) begin
            dur = int'(r[addr][3:0]);
            nt  = r[addr][7] ? 4'd0 : r[addr][7:4];
            if (dur == 0) begin
                expq.push_back({4'd0, 1'b1, 1'b1});
                expq.push_back({4'd0, 1'b0, 1'b0});
                break;
            end
            repeat (dur * T) expq.push_back({nt, 1'b1, 1'b0});
            repeat (T) expq.push_back({4'd0, 1'b1, 1'b0});
            if (addr == depth - 1) begin
                expq.push_back({4'd0, 1'b1, 1'b1});
                expq.push_back({4'd0, 1'b0, 1'b0});
                break;
            end
            expq.push_back({4'd0, 1'b1, 1'b0});
            expq.push_back({4'd0, 1'b1, 1'b0});
            addr++;
        end
        exp_last_addr = addr;
    endfunction

    function automatic logic [3:0] lowest_ref(input logic [6:0] k);
        for (int i = 0; i < 7; i++) if (k[i]) return 4'(i + 1);
        return 4'd0;
    endfunction

    task automatic apply_reset();
        rst = 1'b1; mode = 3'b000; keys = 7'd0; start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_song(input bit second, input int restart_at);
        exp_t obs;
        @(negedge clk); start = 1'b1;
        for (int j = 0; j < expq.size(); j++) begin
            @(negedge clk);
            start = (j == restart_at);
            obs = second ? {note_out2, busy2, done2} : {note_out, busy, done};
            checks++;
            if (obs !== expq[j])
                $display("FAIL song_cycle%0d: got note=%0d busy=%b done=%b, want note=%0d busy=%b done=%b",
                         j, obs.note, obs.busy, obs.done, expq[j].note, expq[j].busy, expq[j].done);
            else passes++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({rom_addr, note_out, led_hint, busy, done, wrong_cnt} !== '0)
            $display("FAIL reset_state: got addr=%0d note=%0d led=%b busy=%b done=%b wrong=%0d, want all 0",
                     rom_addr, note_out, led_hint, busy, done, wrong_cnt);
        else passes++;
        rom1[0] = 8'h32; rom1[1] = 8'h51; rom1[2] = 8'h00;
        mode = 3'b010;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (17) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({rom_addr, note_out, busy} !== '0)
            $display("FAIL async_reset: got addr=%0d note=%0d busy=%b, want 0 0 0", rom_addr, note_out, busy);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_auto_play();
        int n;
        apply_reset();
        mode = 3'b010;
        rom1[0] = 8'h32; rom1[1] = 8'h51; rom1[2] = 8'h00;
        build_timeline(rom1, 64);
        run_song(1'b0, $urandom_range(2, expq.size() - 3));
        checks++;
        if (rom_addr !== 6'(exp_last_addr)) $display("FAIL auto_end_addr: got %0d want %0d", rom_addr, exp_last_addr);
        else passes++;
        // Random songs, back to back without reset.
        repeat (3) begin
            n = $urandom_range(2, 5);
            for (int i = 0; i < n; i++) rom1[i] = {4'($urandom_range(0, 15)), 4'($urandom_range(1, 3))};
            rom1[n] = {4'($urandom_range(0, 15)), 4'd0};
            build_timeline(rom1, 64);
            run_song(1'b0, $urandom_range(0, expq.size() - 3));
            checks++;
            if (rom_addr !== 6'(n) || wrong_cnt !== 8'd0)
                $display("FAIL random_song_end: got addr=%0d wrong=%0d want addr=%0d wrong=0", rom_addr, wrong_cnt, n);
            else passes++;
        end
    endtask

    task automatic test_no_wrap();
        logic [7:0] tmp [64];
        apply_reset();
        mode = 3'b010;
        for (int i = 0; i < 64; i++) tmp[i] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            rom2[i] = {4'($urandom_range(1, 7)), 4'($urandom_range(1, 2))};
            tmp[i]  = rom2[i];
        end
        build_timeline(tmp, 4);
        run_song(1'b1, -1);
        checks++;
        if (rom_addr2 !== 2'd3 || exp_last_addr != 3) $display("FAIL no_wrap_addr: got %0d want 3", rom_addr2);
        else passes++;
        @(negedge clk);
        checks++;
        if (busy2 !== 1'b0 || rom_addr2 !== 2'd3) $display("FAIL no_wrap_idle: got busy=%b addr=%0d want busy=0 addr=3", busy2, rom_addr2);
        else passes++;
    endtask

    task automatic test_free();
        logic [6:0] v;
        apply_reset();
        for (int i = 0; i < 14; i++) begin
            v = (i == 0) ? 7'b0101000 : (i == 1) ? 7'd0 : 7'($urandom);
            @(negedge clk);
            mode = 3'b001; keys = v;
            @(negedge clk);
            checks++;
            if (note_out !== lowest_ref(v)) $display("FAIL free_note keys=%b: got %0d want %0d", v, note_out, lowest_ref(v));
            else passes++;
        end
        keys = 7'd0;
    endtask

    task automatic test_learning();
        int         nwrong;
        int         k;
        logic [3:0] want;
        apply_reset();
        mode = 3'b100;
        rom1[0] = 8'h32; rom1[1] = 8'h51; rom1[2] = 8'h00;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (led_hint !== 7'b0000100 || note_out !== 4'd0) $display("FAIL learn_hint1: got led=%b note=%0d want 0000100 0", led_hint, note_out);
        else passes++;
        nwrong = $urandom_range(1, 4);
        for (int i = 0; i < nwrong; i++) begin
            k = $urandom_range(0, 5);
            if (k >= 2) k++;
            keys = 7'(1 << k);
            @(negedge clk);
            checks++;
            if (wrong_cnt !== 8'(i + 1) || note_out !== 4'd0 || led_hint !== 7'b0000100)
                $display("FAIL learn_wrong%0d: got wrong=%0d note=%0d led=%b want %0d 0 0000100", i, wrong_cnt, note_out, led_hint, i + 1);
            else passes++;
            keys = 7'd0;
            @(negedge clk);
        end
        keys = 7'b0000100 | (7'($urandom) & 7'b1111011);
        @(negedge clk);
        keys = 7'd0;
        checks++;
        if (note_out !== 4'd3 || led_hint !== 7'd0 || wrong_cnt !== 8'(nwrong))
            $display("FAIL learn_press1: got note=%0d led=%b wrong=%0d want 3 0 %0d", note_out, led_hint, wrong_cnt, nwrong);
        else passes++;
        for (int c = 1; c < 14; c++) begin
            @(negedge clk);
            want = (c < 8) ? 4'd3 : 4'd0;
            checks++;
            if (note_out !== want) $display("FAIL learn_play1 c%0d: got %0d want %0d", c, note_out, want);
            else passes++;
        end
        @(negedge clk);
        checks++;
        if (led_hint !== 7'b0010000) $display("FAIL learn_hint2: got %b want 0010000", led_hint);
        else passes++;
        keys = 7'b0010000;
        @(negedge clk);
        keys = 7'd0;
        checks++;
        if (note_out !== 4'd5) $display("FAIL learn_press2: got %0d want 5", note_out);
        else passes++;
        repeat (10) @(negedge clk);
        checks++;
        if (done !== 1'b1 || wrong_cnt !== 8'(nwrong)) $display("FAIL learn_done: got done=%b wrong=%0d want 1 %0d", done, wrong_cnt, nwrong);
        else passes++;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL learn_idle: got busy=%b done=%b want 0 0", busy, done);
        else passes++;
    endtask

    task automatic test_abort();
        int done_seen;
        apply_reset();
        mode = 3'b010;
        rom1[0] = 8'h32; rom1[1] = 8'h51; rom1[2] = 8'h00;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (note_out !== 4'd3) $display("FAIL abort_pre: got %0d want 3", note_out);
        else passes++;
        mode = 3'b001;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || note_out !== 4'd0 || done !== 1'b0 || led_hint !== 7'd0)
            $display("FAIL abort_state: got busy=%b note=%0d done=%b led=%b want 0 0 0 0", busy, note_out, done, led_hint);
        else passes++;
        done_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (done) done_seen++;
        checks++;
        if (busy !== 1'b0 || done_seen != 0) $display("FAIL abort_free_start: got busy=%b done_pulses=%0d want 0 0", busy, done_seen);
        else passes++;
        mode = 3'b000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) $display("FAIL idle_mode_start: got busy=%b want 0", busy);
        else passes++;
        mode = 3'b010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || rom_addr !== 6'd0) $display("FAIL restart_after_abort: got busy=%b addr=%0d want 1 0", busy, rom_addr);
        else passes++;
    endtask

`ifdef LEARN_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        mode = 3'b100;
        rom1[0] = 8'h32; rom1[1] = 8'h51; rom1[2] = 8'h00;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        repeat (63) @(negedge clk);
        checks++;
        if (led_hint !== 7'b0000100 || wrong_cnt !== 8'd0) $display("FAIL timeout_early: got led=%b wrong=%0d want 0000100 0", led_hint, wrong_cnt);
        else passes++;
        @(negedge clk);
        checks++;
        if (led_hint !== 7'd0 || wrong_cnt !== 8'd1 || note_out !== 4'd0 || busy !== 1'b1)
            $display("FAIL timeout_skip: got led=%b wrong=%0d note=%0d busy=%b want 0 1 0 1", led_hint, wrong_cnt, note_out, busy);
        else passes++;
        repeat (6) @(negedge clk);
        checks++;
        if (led_hint !== 7'b0010000 || wrong_cnt !== 8'd1) $display("FAIL timeout_next: got led=%b wrong=%0d want 0010000 1", led_hint, wrong_cnt);
        else passes++;
        mode = 3'b000;
        @(negedge clk);
    endtask
`else
    task automatic test_saturation();
        apply_reset();
        mode = 3'b100;
        rom1[0] = 8'h32; rom1[1] = 8'h51; rom1[2] = 8'h00;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            keys = 7'b0000001;
            @(negedge clk);
            keys = 7'd0;
            if (i == 0 || i == 254 || i == 255 || i == 299) begin
                checks++;
                if (wrong_cnt !== 8'((i + 1 > 255) ? 255 : i + 1))
                    $display("FAIL saturate_press%0d: got %0d want %0d", i, wrong_cnt, (i + 1 > 255) ? 255 : i + 1);
                else passes++;
            end
            @(negedge clk);
        end
        checks++;
        if (led_hint !== 7'b0000100 || note_out !== 4'd0) $display("FAIL saturate_hold: got led=%b note=%0d want 0000100 0", led_hint, note_out);
        else passes++;
        mode = 3'b000;
        @(negedge clk);
        mode = 3'b100; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (wrong_cnt !== 8'd0 || led_hint !== 7'b0000100) $display("FAIL restart_clears_wrong: got wrong=%0d led=%b want 0 0000100", wrong_cnt, led_hint);
        else passes++;
        mode = 3'b000;
        @(negedge clk);
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) rom1[i] = 8'h00;
        for (int i = 0; i < 4; i++) rom2[i] = 8'h11;
        test_reset();
        test_auto_play();
        test_no_wrap();
        test_free();
        test_learning();
        test_abort();
`ifdef LEARN_TIMEOUT_EN
        test_timeout();
`else
        test_saturation();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
